// File: rtl/r256x18_fifo_ctl.sv
// FIFO controller for a 256x18 dual-port RAM macro in the SDIO host data path.
// Drives the RAM write port from producer pushes and prefetches the head entry
// through the registered RAM read port into a show-ahead valid/ready pop interface.
module r256x18_fifo_ctl #(
   parameter int unsigned AW     = 8,
   parameter int unsigned DW     = 18,
   parameter int unsigned AF_LVL = 248,
   parameter int unsigned AE_LVL = 8
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Flush,
   input  logic          Push,
   input  logic [DW-1:0] PushData,
   output logic          Full,
   output logic          AlmostFull,
   input  logic          Pop,
   output logic          RdValid,
   output logic [DW-1:0] RdData,
   output logic          Empty,
   output logic          AlmostEmpty,
   output logic [AW:0]   Count,
   output logic          Overflow,
   output logic          Underflow,
   output logic [AW-1:0] WA,
   output logic [DW-1:0] WD,
   output logic [1:0]    WEN,
   output logic          WD_SEL,
   output logic [AW-1:0] RA,
   output logic          RD_SEL,
   input  logic [DW-1:0] RD
);

   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(1 << AW);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] ra_q;
   logic [CW-1:0] cnt;
   logic          rd_valid;
   logic          inflight;
   logic          ovf;
   logic          udf;

   logic          push_ok;
   logic          pop_ok;
   logic          fetch;
   logic          wr_go;
   logic [CW-1:0] mem_pend;

   // Accept/pop/fetch decisions; head entry and in-flight read are excluded from mem_pend
   always_comb begin
      push_ok  = Push && !Full && !Flush;
      pop_ok   = Pop && rd_valid && !Flush;
      mem_pend = cnt - CW'(rd_valid) - CW'(inflight);
      fetch    = (mem_pend != '0) && (!rd_valid || Pop) && !inflight && !Flush;
      wr_go    = push_ok && Rst_n;
   end

   // RAM port drive and occupancy flags, all derived combinationally
   always_comb begin
      WA          = wptr;
      WD          = PushData;
      WEN         = {2{wr_go}};
      WD_SEL      = wr_go;
      RA          = fetch ? rptr : ra_q;
      RD_SEL      = fetch || inflight || rd_valid;
      RdData      = RD;
      RdValid     = rd_valid;
      Count       = cnt;
      Overflow    = ovf;
      Underflow   = udf;
      Full        = (cnt == DEPTH_C);
      Empty       = (cnt == '0);
      AlmostFull  = (cnt >= AF_C);
      AlmostEmpty = (cnt <= AE_C);
   end

   // Pointer, occupancy, prefetch pipeline and sticky error state
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         ra_q     <= '0;
         cnt      <= '0;
         rd_valid <= 1'b0;
         inflight <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (Flush) begin
         wptr     <= '0;
         rptr     <= '0;
         ra_q     <= '0;
         cnt      <= '0;
         rd_valid <= 1'b0;
         inflight <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         ra_q <= RA;
         if (push_ok) wptr <= wptr + AW'(1);
         if (fetch)   rptr <= rptr + AW'(1);
         if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
         else if (pop_ok && !push_ok) cnt <= cnt - CW'(1);
         inflight <= fetch;
         // a returning fetch refills the head slot even in the cycle it is popped
         if (inflight)    rd_valid <= 1'b1;
         else if (pop_ok) rd_valid <= 1'b0;
         if (Push && Full)     ovf <= 1'b1;
         if (Pop && !rd_valid) udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_r256x18_fifo_ctl.sv
// Directed bench for r256x18_fifo_ctl with a behavioural 256x18 registered-read RAM.
module tb_r256x18_fifo_ctl;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Flush;
   logic        Push;
   logic [17:0] PushData;
   logic        Full;
   logic        AlmostFull;
   logic        Pop;
   logic        RdValid;
   logic [17:0] RdData;
   logic        Empty;
   logic        AlmostEmpty;
   logic [8:0]  Count;
   logic        Overflow;
   logic        Underflow;
   logic [7:0]  WA;
   logic [17:0] WD;
   logic [1:0]  WEN;
   logic        WD_SEL;
   logic [7:0]  RA;
   logic        RD_SEL;
   logic [17:0] RD;

   int checks   = 0;
   int failures = 0;

   logic [17:0] mem [0:255];
   logic [17:0] rd_q = '0;

   always #5 Clk = ~Clk;

   r256x18_fifo_ctl dut (
      .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Push(Push), .PushData(PushData),
      .Full(Full), .AlmostFull(AlmostFull), .Pop(Pop), .RdValid(RdValid), .RdData(RdData),
      .Empty(Empty), .AlmostEmpty(AlmostEmpty), .Count(Count), .Overflow(Overflow),
      .Underflow(Underflow), .WA(WA), .WD(WD), .WEN(WEN), .WD_SEL(WD_SEL), .RA(RA),
      .RD_SEL(RD_SEL), .RD(RD)
   );

   // RAM macro: registered read, output forced to 0 when not selected
   always @(posedge Clk) begin
      if (WEN == 2'b11 && WD_SEL) mem[WA] <= WD;
      rd_q <= RD_SEL ? mem[RA] : 18'h0;
   end
   assign RD = rd_q;

   // Wait (bounded) for a valid head, sample it, then pop it in one cycle
   task automatic pop_one(output logic [17:0] d, output bit ok);
      int n = 0;
      while (RdValid !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
      ok = (RdValid === 1'b1);
      d  = RdData;
      if (ok) begin Pop = 1'b1; @(negedge Clk); Pop = 1'b0; end
   endtask

   task automatic push_seq(input int first, input int num);
      for (int i = 0; i < num; i++) begin
         @(negedge Clk); Push = 1'b1; PushData = 18'(first + i);
      end
      @(negedge Clk); Push = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge Clk); Flush = 1'b1;
      @(negedge Clk); Flush = 1'b0;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Flush = 1'b0; Push = 1'b1; PushData = 18'h12345; Pop = 1'b0;
      #12;
      checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", Empty); end
      checks++; if (AlmostEmpty !== 1'b1 || Full !== 1'b0 || AlmostFull !== 1'b0) begin failures++; $display("FAIL reset_flags got ae=%b f=%b af=%b exp 1/0/0", AlmostEmpty, Full, AlmostFull); end
      checks++; if (WEN !== 2'b00 || WD_SEL !== 1'b0 || RD_SEL !== 1'b0) begin failures++; $display("FAIL reset_en got wen=%b wdsel=%b rdsel=%b exp 0", WEN, WD_SEL, RD_SEL); end
      checks++; if (WA !== 8'd0 || RA !== 8'd0 || Count !== 9'd0 || RdValid !== 1'b0) begin failures++; $display("FAIL reset_state got wa=%0d ra=%0d cnt=%0d rv=%b exp 0", WA, RA, Count, RdValid); end
      Push = 1'b0;
      @(negedge Clk); Rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge Clk); Push = 1'b1; PushData = 18'h00001; #1;
      checks++; if (WEN !== 2'b11 || WA !== 8'd0 || WD !== 18'h00001 || WD_SEL !== 1'b1) begin failures++; $display("FAIL push_port got wen=%b wa=%0d wd=%h exp 11/0/00001", WEN, WA, WD); end
      @(negedge Clk); Push = 1'b0; #1;
      checks++; if (Count !== 9'd1 || RA !== 8'd0 || RD_SEL !== 1'b1 || RdValid !== 1'b0) begin failures++; $display("FAIL fetch_cycle got cnt=%0d ra=%0d rdsel=%b rv=%b exp 1/0/1/0", Count, RA, RD_SEL, RdValid); end
      @(negedge Clk); #1;
      checks++; if (RdValid !== 1'b0 || RD !== 18'h00001) begin failures++; $display("FAIL return_cycle got rv=%b rd=%h exp 0/00001", RdValid, RD); end
      @(negedge Clk); #1;
      checks++; if (RdValid !== 1'b1 || RdData !== 18'h00001) begin failures++; $display("FAIL head_valid got rv=%b data=%h exp 1/00001", RdValid, RdData); end
      Pop = 1'b1;
      @(negedge Clk); Pop = 1'b0; #1;
      checks++; if (Empty !== 1'b1 || Count !== 9'd0 || Underflow !== 1'b0) begin failures++; $display("FAIL after_pop got empty=%b cnt=%0d udf=%b exp 1/0/0", Empty, Count, Underflow); end
   endtask

   task automatic test_fill_drain();
      logic [17:0] d; bit ok; int bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge Clk);
         if (i == 8)   begin checks++; if (AlmostEmpty !== 1'b1) begin failures++; $display("FAIL ae_at_8 got=%b exp=1", AlmostEmpty); end end
         if (i == 9)   begin checks++; if (AlmostEmpty !== 1'b0) begin failures++; $display("FAIL ae_at_9 got=%b exp=0", AlmostEmpty); end end
         if (i == 247) begin checks++; if (AlmostFull !== 1'b0) begin failures++; $display("FAIL af_at_247 got=%b exp=0", AlmostFull); end end
         if (i == 248) begin checks++; if (AlmostFull !== 1'b1) begin failures++; $display("FAIL af_at_248 got=%b exp=1", AlmostFull); end end
         Push = 1'b1; PushData = 18'(i);
      end
      @(negedge Clk); PushData = 18'h3AAAA; #1;
      checks++; if (Full !== 1'b1 || Count !== 9'd256 || AlmostFull !== 1'b1) begin failures++; $display("FAIL full got full=%b cnt=%0d af=%b exp 1/256/1", Full, Count, AlmostFull); end
      checks++; if (WEN !== 2'b00 || WD_SEL !== 1'b0) begin failures++; $display("FAIL push_when_full_wen got=%b exp=00", WEN); end
      @(negedge Clk); Push = 1'b0; #1;
      checks++; if (Overflow !== 1'b1 || Count !== 9'd256) begin failures++; $display("FAIL overflow got ovf=%b cnt=%0d exp 1/256", Overflow, Count); end
      for (int i = 0; i < 256; i++) begin
         pop_one(d, ok);
         checks++; if (!ok || d !== 18'(i)) begin failures++; bad++; if (bad < 5) $display("FAIL drain_order idx=%0d got=%h ok=%b exp=%h", i, d, ok, 18'(i)); end
      end
      #1;
      checks++; if (Empty !== 1'b1 || Count !== 9'd0) begin failures++; $display("FAIL drain_empty got empty=%b cnt=%0d exp 1/0", Empty, Count); end
   endtask

   task automatic test_wrap();
      logic [17:0] d; bit ok; int bad = 0;
      do_flush();
      push_seq(0, 200);
      for (int i = 0; i < 200; i++) begin
         pop_one(d, ok);
         checks++; if (!ok || d !== 18'(i)) begin failures++; bad++; if (bad < 5) $display("FAIL wrap_first idx=%0d got=%h exp=%h", i, d, 18'(i)); end
      end
      for (int v = 200; v < 400; v++) begin
         @(negedge Clk); Push = 1'b1; PushData = 18'(v); #1;
         if (v == 255) begin checks++; if (WA !== 8'd255) begin failures++; $display("FAIL wa_255 got=%0d exp=255", WA); end end
         if (v == 256) begin checks++; if (WA !== 8'd0) begin failures++; $display("FAIL wa_wrap got=%0d exp=0", WA); end end
      end
      @(negedge Clk); Push = 1'b0;
      checks++; if (Count !== 9'd200) begin failures++; $display("FAIL wrap_count got=%0d exp=200", Count); end
      for (int v = 200; v < 400; v++) begin
         pop_one(d, ok);
         checks++; if (!ok || d !== 18'(v)) begin failures++; bad++; if (bad < 5) $display("FAIL wrap_order val=%0d got=%h exp=%h", v, d, 18'(v)); end
      end
   endtask

   task automatic test_boundaries();
      logic [17:0] d; bit ok; int n = 0;
      do_flush();
      push_seq(1000, 256);
      while (RdValid !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
      checks++; if (RdValid !== 1'b1 || Overflow !== 1'b0) begin failures++; $display("FAIL full_head got rv=%b ovf=%b exp 1/0", RdValid, Overflow); end
      Push = 1'b1; Pop = 1'b1; PushData = 18'h2BEEF; #1;
      checks++; if (WEN !== 2'b00) begin failures++; $display("FAIL full_pushpop_wen got=%b exp=00", WEN); end
      @(negedge Clk); Push = 1'b0; Pop = 1'b0; #1;
      checks++; if (Overflow !== 1'b1 || Count !== 9'd255) begin failures++; $display("FAIL full_pushpop got ovf=%b cnt=%0d exp 1/255", Overflow, Count); end
      do_flush();
      @(negedge Clk); Pop = 1'b1;
      @(negedge Clk); Pop = 1'b0; #1;
      checks++; if (Underflow !== 1'b1 || Count !== 9'd0 || Empty !== 1'b1) begin failures++; $display("FAIL pop_empty got udf=%b cnt=%0d exp 1/0", Underflow, Count); end
      @(negedge Clk); Push = 1'b1; Pop = 1'b1; PushData = 18'h15A5A;
      @(negedge Clk); Push = 1'b0; Pop = 1'b0; #1;
      checks++; if (Count !== 9'd1) begin failures++; $display("FAIL pushpop_empty got cnt=%0d exp=1", Count); end
      pop_one(d, ok);
      checks++; if (!ok || d !== 18'h15A5A) begin failures++; $display("FAIL pushpop_data got=%h exp=15a5a", d); end
   endtask

   task automatic test_flush();
      int n = 0;
      push_seq(500, 50);
      while (RdValid !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
      checks++; if (Count !== 9'd50 || RdValid !== 1'b1 || Underflow !== 1'b1) begin failures++; $display("FAIL pre_flush got cnt=%0d rv=%b udf=%b exp 50/1/1", Count, RdValid, Underflow); end
      Flush = 1'b1; Push = 1'b1; PushData = 18'h0F0F0; #1;
      checks++; if (WEN !== 2'b00) begin failures++; $display("FAIL flush_wen got=%b exp=00", WEN); end
      @(negedge Clk); Flush = 1'b0; Push = 1'b0; #1;
      checks++; if (Count !== 9'd0 || RdValid !== 1'b0 || Empty !== 1'b1 || Underflow !== 1'b0 || Overflow !== 1'b0) begin failures++; $display("FAIL flush got cnt=%0d rv=%b empty=%b udf=%b ovf=%b exp 0/0/1/0/0", Count, RdValid, Empty, Underflow, Overflow); end
      @(negedge Clk); #1;
      checks++; if (Count !== 9'd0 || RD_SEL !== 1'b0) begin failures++; $display("FAIL flush_hold got cnt=%0d rdsel=%b exp 0/0", Count, RD_SEL); end
   endtask

   task automatic test_reset_midfetch();
      logic [17:0] d; bit ok;
      @(negedge Clk); Push = 1'b1; PushData = 18'h00011;
      @(negedge Clk); PushData = 18'h00022;
      @(negedge Clk); Push = 1'b0; #1;
      checks++; if (RD_SEL !== 1'b1 || RdValid !== 1'b0 || Count !== 9'd2) begin failures++; $display("FAIL inflight got rdsel=%b rv=%b cnt=%0d exp 1/0/2", RD_SEL, RdValid, Count); end
      Rst_n = 1'b0; #1;
      checks++; if (Count !== 9'd0 || RdValid !== 1'b0 || RD_SEL !== 1'b0) begin failures++; $display("FAIL reset_mid got cnt=%0d rv=%b rdsel=%b exp 0/0/0", Count, RdValid, RD_SEL); end
      @(negedge Clk); Rst_n = 1'b1;
      @(negedge Clk); Push = 1'b1; PushData = 18'h3FFFF;
      @(negedge Clk); Push = 1'b0;
      pop_one(d, ok);
      checks++; if (!ok || d !== 18'h3FFFF) begin failures++; $display("FAIL roundtrip got=%h ok=%b exp=3ffff", d, ok); end
      #1;
      checks++; if (Count !== 9'd0 || Empty !== 1'b1) begin failures++; $display("FAIL roundtrip_empty got cnt=%0d exp=0", Count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_wrap();
      test_boundaries();
      test_flush();
      test_reset_midfetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
